// File: rtl/conv_encoder_pkg.sv
// conv_pkg: constants, FSM state type and parity helper shared by the
// rate-1/2 convolutional encoder and the matching viterbi_core benches.
// Generator words are octal, K bits wide, MSB tapping the current input bit.
package conv_pkg;

  localparam int K_DEF      = 4;
  localparam int G0_OCT_DEF = 'o17;
  localparam int G1_OCT_DEF = 'o13;

  // Widest legal constraint length; the parity helper works on this width.
  localparam int K_MAX = 8;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } conv_state_e;

  // XOR reduction of the generator-selected window bits.
  function automatic logic conv_parity(input logic [K_MAX-1:0] window,
                                       input logic [K_MAX-1:0] gen);
    return ^(window & gen);
  endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// conv_encoder_if: bit-stream input handshake plus symbol-stream output
// handshake of conv_encoder.
//   master : bit source / symbol sink side (drives in_bit*, tx_sym_ready)
//   slave  : the encoder (drives in_bit_ready, tx_sym*)
interface conv_encoder_if;

  logic       in_bit_valid;
  logic       in_bit_ready;
  logic       in_bit;
  logic       in_last;
  logic       tx_sym_valid;
  logic       tx_sym_ready;
  logic [1:0] tx_sym;
  logic       tx_sym_last;

  modport master (
    output in_bit_valid, in_bit, in_last, tx_sym_ready,
    input  in_bit_ready, tx_sym_valid, tx_sym, tx_sym_last
  );

  modport slave (
    input  in_bit_valid, in_bit, in_last, tx_sym_ready,
    output in_bit_ready, tx_sym_valid, tx_sym, tx_sym_last
  );

endinterface

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 feed-forward convolutional encoder.
// Each accepted bit u forms the window W = {u, s[K-2:0]} (s[K-2] newest),
// producing tx_sym = {^(W&G0), ^(W&G1)} in a single output register.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : conv_encoder_if.slave -- in_bit_valid/ready, in_bit, in_last,
//           tx_sym_valid/ready, tx_sym[1:0] (1=G0, 0=G1), tx_sym_last
//
// Build option CONV_ENC_TAIL_EN:
//   defined   : after the last data bit, K-1 zero tail bits are encoded so
//               the frame ends in state 0; the last tail symbol is flagged.
//   undefined : no tail; tx_sym_last follows in_last of the accepted bit and
//               the memory is cleared as that bit is accepted.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int G0_OCT = G0_OCT_DEF,
  parameter int G1_OCT = G1_OCT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  conv_encoder_if.slave  bus
);

  localparam int M = K - 1;
  localparam logic [K_MAX-1:0] G0_MASK = K_MAX'(G0_OCT & ((1 << K) - 1));
  localparam logic [K_MAX-1:0] G1_MASK = K_MAX'(G1_OCT & ((1 << K) - 1));

  logic [M-1:0] mem_q, mem_d;
  logic [1:0]   sym_q, sym_d;
  logic         vld_q, vld_d;
  logic         last_q, last_d;

  logic         load_en;
  logic         in_ready;
  logic         produce;    // a symbol is encoded and loaded this cycle
  logic         u;          // bit entering the window
  logic         sym_last;   // last flag for the symbol being loaded
  logic         clear_mem;  // restart from state 0 after this symbol

  logic [K-1:0]     win;
  logic [K_MAX-1:0] win_ext;
  logic             p0, p1;

  // The output slot can take a symbol when empty or being drained now.
  assign load_en = !vld_q || bus.tx_sym_ready;

`ifdef CONV_ENC_TAIL_EN
  localparam int TW = $clog2(K);

  conv_state_e   state_q, state_d;
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_DATA;
      tail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    in_ready   = 1'b0;
    produce    = 1'b0;
    u          = 1'b0;
    sym_last   = 1'b0;
    clear_mem  = 1'b0;
    case (state_q)
      ST_DATA: begin
        in_ready = load_en;
        if (bus.in_bit_valid && load_en) begin
          produce = 1'b1;
          u       = bus.in_bit;
          if (bus.in_last) begin
            state_d    = ST_TAIL;
            tail_cnt_d = TW'(K - 1);
          end
        end
      end
      ST_TAIL: begin
        if (load_en) begin
          produce    = 1'b1;
          tail_cnt_d = tail_cnt_q - TW'(1);
          // Counter about to hit zero: this is the final tail symbol.
          if (tail_cnt_q == TW'(1)) begin
            sym_last = 1'b1;
            state_d  = ST_DATA;
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end
`else
  always_comb begin
    in_ready  = load_en;
    produce   = bus.in_bit_valid && load_en;
    u         = bus.in_bit;
    sym_last  = bus.in_last;
    clear_mem = produce && bus.in_last;
  end
`endif

  always_comb begin
    win            = {u, mem_q};
    win_ext        = '0;
    win_ext[K-1:0] = win;
    p0             = conv_parity(win_ext, G0_MASK);
    p1             = conv_parity(win_ext, G1_MASK);
  end

  // Output register and memory advance only together, so a stalled symbol
  // holds both the output and the encoder state.
  always_comb begin
    mem_d  = mem_q;
    sym_d  = sym_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (load_en) begin
      vld_d = produce;
      if (produce) begin
        sym_d  = {p0, p1};
        last_d = sym_last;
        mem_d  = clear_mem ? '0 : win[K-1:1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      sym_q  <= 2'b00;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      sym_q  <= sym_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign bus.in_bit_ready = in_ready;
  assign bus.tx_sym_valid = vld_q;
  assign bus.tx_sym       = sym_q;
  assign bus.tx_sym_last  = last_q;

endmodule

// File: tb/tb_conv_encoder.sv
module tb_conv_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_encoder_if bus ();

  conv_encoder #(.K(4), .G0_OCT('o17), .G1_OCT('o13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef CONV_ENC_TAIL_EN
  localparam int TL = 3;
`else
  localparam int TL = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];  // {last, sym} expected, in order
  logic [2:0] rx_q[$];   // {last, sym} observed transfers
  logic [2:0] mem_m;     // model memory, mem_m[2] newest
  int         tail_left;
  logic       stalled;
  logic [2:0] held;
  logic       exp_vld;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [1:0] enc(input logic uu, input logic [2:0] m);
    logic [3:0] w;
    w = {uu, m};
    return {^(w & 4'b1111), ^(w & 4'b1011)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mem_m     = 3'b000;
    tail_left = 0;
    stalled   = 1'b0;
    exp_vld   = 1'b0;
  endtask

  // One clock: check at the negedge, then return 1 time unit after posedge.
  task automatic cycle(output logic acc);
    logic       le;
    logic [2:0] e;
    @(negedge clk);
    le = !bus.tx_sym_valid || bus.tx_sym_ready;
    chk("in_bit_ready", {31'd0, bus.in_bit_ready}, {31'd0, le && (tail_left == 0)});
    if (exp_vld) chk("latency_valid", {31'd0, bus.tx_sym_valid}, 32'd1);
    if (stalled) chk("stall_hold", {29'd0, bus.tx_sym_last, bus.tx_sym}, {29'd0, held});
    if (bus.tx_sym_valid && bus.tx_sym_ready) begin
      rx_q.push_back({bus.tx_sym_last, bus.tx_sym});
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL extra_sym observed=%0h expected=none", {bus.tx_sym_last, bus.tx_sym});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sym", {29'd0, bus.tx_sym_last, bus.tx_sym}, {29'd0, e});
      end
    end
    stalled = bus.tx_sym_valid && !bus.tx_sym_ready;
    held    = {bus.tx_sym_last, bus.tx_sym};
    exp_vld = 1'b0;
    if (tail_left > 0 && le) begin
      tail_left--;
      exp_vld = 1'b1;
    end
    acc = bus.in_bit_valid && bus.in_bit_ready;
    if (acc) begin
      exp_vld = 1'b1;
`ifdef CONV_ENC_TAIL_EN
      exp_q.push_back({1'b0, enc(bus.in_bit, mem_m)});
      mem_m = {bus.in_bit, mem_m[2:1]};
      if (bus.in_last) begin
        for (int i = 0; i < 3; i++) begin
          exp_q.push_back({i == 2, enc(1'b0, mem_m)});
          mem_m = {1'b0, mem_m[2:1]};
        end
        tail_left = 3;
      end
`else
      exp_q.push_back({bus.in_last, enc(bus.in_bit, mem_m)});
      mem_m = bus.in_last ? 3'b000 : {bus.in_bit, mem_m[2:1]};
`endif
    end
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 = ready high, 1 = random ready, 2 = ready low
  function automatic logic rdy(input int rmode);
    if (rmode == 1) return 1'($urandom_range(0, 1));
    return (rmode == 0);
  endfunction

  task automatic send_bit(input logic b, input logic last, input int rmode);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    bus.in_bit_valid = 1'b1;
    bus.in_bit       = b;
    bus.in_last      = last;
    while (!acc && n < 200) begin
      bus.tx_sym_ready = rdy(rmode);
      cycle(acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $error("FAIL accept_timeout observed=0 expected=1");
    end
    bus.in_bit_valid = 1'b0;
    bus.in_bit       = 1'b0;
    bus.in_last      = 1'b0;
  endtask

  task automatic drain(input int rmode);
    logic acc;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || bus.tx_sym_valid) && n < 400) begin
      bus.tx_sym_ready = rdy(rmode);
      cycle(acc);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
    end
    bus.tx_sym_ready = 1'b1;
  endtask

  logic [2:0] imp_exp[4];
  logic       rb;
  int         n;
  logic       acc;

  initial begin
    imp_exp = '{3'b011, 3'b010, 3'b011, 3'b111};
    rst_n = 1'b0;
    bus.in_bit_valid = 1'b0;
    bus.in_bit       = 1'b0;
    bus.in_last      = 1'b0;
    bus.tx_sym_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.tx_sym_valid}, 32'd0);
    chk("rst_sym",   {30'd0, bus.tx_sym},       32'd0);
    chk("rst_last",  {31'd0, bus.tx_sym_last},  32'd0);
    chk("rst_ready", {31'd0, bus.in_bit_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Impulse
    rx_q.delete();
    send_bit(1'b1, 1'b1, 0);
    drain(0);
    chk("impulse_count", rx_q.size(), 1 + TL);
`ifdef CONV_ENC_TAIL_EN
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) chk("impulse_sym", {29'd0, rx_q[i]}, {29'd0, imp_exp[i]});
`else
    if (rx_q.size() > 0) chk("impulse_sym", {29'd0, rx_q[0]}, 32'b111);
`endif

    // All-zero frame of 8 bits
    rx_q.delete();
    for (int i = 0; i < 8; i++) send_bit(1'b0, i == 7, 0);
    drain(0);
    chk("zero_count", rx_q.size(), 8 + TL);
    for (int i = 0; i < 8 + TL; i++)
      if (i < rx_q.size()) chk("zero_sym", {29'd0, rx_q[i]}, {29'd0, i == 8 + TL - 1, 2'b00});

    // Tail blocking: frame 1,1,0,1 then a fresh 1-bit frame back to back
    rx_q.delete();
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b1, 1'b1, 0);
    drain(0);
    chk("block_count", rx_q.size(), 5 + 2 * TL);
`ifdef CONV_ENC_TAIL_EN
    if (rx_q.size() > 7) chk("next_frame_first", {29'd0, rx_q[7]}, 32'b011);
`else
    if (rx_q.size() > 4) chk("next_frame_first", {29'd0, rx_q[4]}, 32'b111);
`endif

    // Random backpressure over a 64-bit random frame
    rx_q.delete();
    for (int i = 0; i < 64; i++) begin
      rb = 1'($urandom_range(0, 1));
      send_bit(rb, i == 63, 1);
    end
    drain(1);
    chk("bp_count", rx_q.size(), 64 + TL);

    // Reset while a symbol is pending
    rx_q.delete();
`ifdef CONV_ENC_TAIL_EN
    send_bit(1'b1, 1'b1, 0);
    n = 0;
    while (rx_q.size() < 3 && n < 20) begin
      bus.tx_sym_ready = 1'b1;
      cycle(acc);
      n++;
    end
    chk("pre_rst_rx", rx_q.size(), 3);
`else
    send_bit(1'b1, 1'b0, 2);
`endif
    chk("pre_rst_valid", {31'd0, bus.tx_sym_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.tx_sym_valid}, 32'd0);
    chk("mid_rst_last",  {31'd0, bus.tx_sym_last},  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rx_q.delete();
    send_bit(1'b1, 1'b1, 0);
    drain(0);
    chk("post_rst_count", rx_q.size(), 1 + TL);
    if (rx_q.size() > 0) chk("post_rst_first", {30'd0, rx_q[0][1:0]}, 32'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
